// File: rtl/pipelined_lod_normalizer.sv
// pipelined_lod_normalizer: two-stage leading-one normalizer with exponent clamp and valid/ready flow control
module pipelined_lod_normalizer #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 8,
    parameter int POS_WIDTH = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_mant,
    input  logic [EXP_WIDTH-1:0] in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_mant,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic [POS_WIDTH-1:0] out_pos,
    output logic                 out_zero,
    output logic                 out_underflow
);
    // Common width for comparing the exponent against the requested shift
    localparam int CW = (EXP_WIDTH > POS_WIDTH) ? EXP_WIDTH : POS_WIDTH;

    logic                 s1_valid_q, s2_valid_q;
    logic [WIDTH-1:0]     s1_mant_q, s2_mant_q;
    logic [EXP_WIDTH-1:0] s1_exp_q, s2_exp_q;
    logic [POS_WIDTH-1:0] s1_pos_q, s2_pos_q;
    logic                 s1_zero_q, s2_zero_q, s2_uf_q;

    logic                 adv1, adv2;
    logic [POS_WIDTH-1:0] pos_d;
    logic                 zero_d;
    logic [CW-1:0]        exp_w, sh_req, sh;
    logic                 uf_d;
    logic [WIDTH-1:0]     mant_d;
    logic [EXP_WIDTH-1:0] exp_d;

    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    always_comb begin
        pos_d = '0;
        for (int i = 0; i < WIDTH; i++)
            if (in_mant[i]) pos_d = POS_WIDTH'(i);
        zero_d = ~|in_mant;
    end

    always_comb begin
        exp_w  = CW'(s1_exp_q);
        sh_req = CW'(WIDTH - 1) - CW'(s1_pos_q);
        uf_d   = !s1_zero_q && (exp_w < sh_req);
        sh     = uf_d ? exp_w : sh_req;
        mant_d = s1_mant_q << sh;
        exp_d  = (s1_zero_q || uf_d) ? '0 : EXP_WIDTH'(exp_w - sh_req);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_exp_q   <= '0;
            s1_pos_q   <= '0;
            s1_zero_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_mant_q  <= '0;
            s2_exp_q   <= '0;
            s2_pos_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_uf_q    <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
                s1_mant_q  <= in_mant;
                s1_exp_q   <= in_exp;
                s1_pos_q   <= pos_d;
                s1_zero_q  <= zero_d;
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                s2_mant_q  <= mant_d;
                s2_exp_q   <= exp_d;
                s2_pos_q   <= s1_pos_q;
                s2_zero_q  <= s1_zero_q;
                s2_uf_q    <= uf_d;
            end
        end
    end

    assign out_valid     = s2_valid_q;
    assign out_mant      = s2_mant_q;
    assign out_exp       = s2_exp_q;
    assign out_pos       = s2_pos_q;
    assign out_zero      = s2_zero_q;
    assign out_underflow = s2_uf_q;
endmodule

// File: tb/tb_pipelined_lod_normalizer.sv
// tb_pipelined_lod_normalizer: scoreboard bench with directed, backpressure, random and async-reset phases
module tb_pipelined_lod_normalizer;
    typedef struct packed {
        logic [7:0] mant;
        logic [4:0] exp;
        logic [2:0] pos;
        logic       zero;
        logic       uf;
    } beat_t;

    logic       clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic [7:0] in_mant = 0;
    logic [4:0] in_exp = 0;
    logic       in_ready, out_valid, out_zero, out_underflow;
    logic [7:0] out_mant;
    logic [4:0] out_exp;
    logic [2:0] out_pos;
    int         vectors = 0, miscompares = 0;
    beat_t      sb[$];
    beat_t      exp_b, act_b;
    bit         rnd_bp = 0;

    pipelined_lod_normalizer #(.WIDTH(8), .EXP_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_pos(out_pos),
        .out_zero(out_zero), .out_underflow(out_underflow)
    );

    always #5 clk = ~clk;

    function automatic beat_t model(logic [7:0] m, logic [4:0] e);
        beat_t r;
        bit found;
        r = '0;
        found = 0;
        for (int i = 7; i >= 0; i--)
            if (m[i] && !found) begin r.pos = 3'(i); found = 1; end
        if (m == 0) r.zero = 1;
        else begin
            while (!m[7] && e != 0) begin m = m << 1; e = e - 1; end
            r.mant = m;
            r.exp  = e;
            r.uf   = !m[7];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] m, input logic [4:0] e, input beat_t x);
        int n = 0;
        in_valid = 1; in_mant = m; in_exp = e;
        forever begin
            @(negedge clk);
            if (in_ready) begin sb.push_back(x); break; end
            if (++n > 500) begin
                vectors++; miscompares++;
                $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic send_latency(input logic [7:0] m, input logic [4:0] e, input beat_t x);
        send(m, e, x);
        @(negedge clk) check("latency_early_valid", out_valid, 0);
        @(negedge clk) check("latency_valid", out_valid, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        check("drain_empty", sb.size(), 0);
    endtask

    always @(negedge clk) if (!rst) begin
        if (!out_valid || out_ready) check("in_ready_when_room", in_ready, 1);
        if (out_valid && out_ready) begin
            act_b = {out_mant, out_exp, out_pos, out_zero, out_underflow};
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat: got mant=%h exp=%0d, expected no output", out_mant, out_exp);
            end else begin
                exp_b = sb.pop_front();
                if (act_b !== exp_b) begin
                    miscompares++;
                    $display("FAIL beat: got mant=%h exp=%0d pos=%0d zero=%b uf=%b, expected mant=%h exp=%0d pos=%0d zero=%b uf=%b",
                             act_b.mant, act_b.exp, act_b.pos, act_b.zero, act_b.uf,
                             exp_b.mant, exp_b.exp, exp_b.pos, exp_b.zero, exp_b.uf);
                end
            end
        end
    end

    always @(posedge clk) if (rnd_bp) begin #1 out_ready = 1'($urandom_range(0, 1)); end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] dm [6] = '{8'h05, 8'h00, 8'h80, 8'h01, 8'h03, 8'h40};
    logic [4:0] de [6] = '{5'd3, 5'd17, 5'd0, 5'd7, 5'd0, 5'd31};
    beat_t      dx [6] = '{{8'h28, 5'd0, 3'd2, 1'b0, 1'b1},
                          {8'h00, 5'd0, 3'd0, 1'b1, 1'b0},
                          {8'h80, 5'd0, 3'd7, 1'b0, 1'b0},
                          {8'h80, 5'd0, 3'd0, 1'b0, 1'b0},
                          {8'h03, 5'd0, 3'd1, 1'b0, 1'b1},
                          {8'h80, 5'd30, 3'd6, 1'b0, 1'b0}};

    initial begin
        logic [7:0] m;
        logic [4:0] e;
        int quiet;
        repeat (2) @(posedge clk); #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_data", {out_mant, out_exp, out_pos, out_zero, out_underflow}, 0);
        rst = 0;
        @(posedge clk); #1;
        send_latency(8'h05, 5'd10, {8'hA0, 5'd5, 3'd2, 1'b0, 1'b0});
        for (int i = 0; i < 6; i++) send(dm[i], de[i], dx[i]);
        drain();

        out_ready = 0;
        send(8'h10, 5'd20, {8'h80, 5'd17, 3'd4, 1'b0, 1'b0});
        send(8'hFF, 5'd1, {8'hFF, 5'd1, 3'd7, 1'b0, 1'b0});
        in_valid = 1; in_mant = 8'h06; in_exp = 5'd2;
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_hold", {out_mant, out_exp}, {8'h80, 5'd17});
        check("full_in_ready_held", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1;
        send(8'h06, 5'd2, {8'h18, 5'd0, 3'd2, 1'b0, 1'b1});
        drain();

        rnd_bp = 1;
        for (int i = 0; i < 1000; i++) begin
            m = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
            e = 5'($urandom_range(0, 31));
            send(m, e, model(m, e));
            if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        end
        rnd_bp = 0;
        @(posedge clk); #2;
        out_ready = 1;
        drain();

        @(posedge clk); #1;
        out_ready = 0;
        send(8'h21, 5'd9, model(8'h21, 5'd9));
        send(8'h02, 5'd4, model(8'h02, 5'd4));
        #2 rst = 1;
        sb.delete();
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_data", {out_mant, out_exp, out_pos, out_zero, out_underflow}, 0);
        check("async_rst_in_ready", in_ready, 1);
        @(posedge clk); @(posedge clk); #3;
        rst = 0;
        out_ready = 1;
        quiet = 0;
        repeat (5) @(negedge clk) quiet += int'(out_valid);
        check("post_rst_quiet", quiet, 0);
        @(posedge clk); #1;
        send_latency(8'h0C, 5'd6, {8'hC0, 5'd2, 3'd3, 1'b0, 1'b0});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipelined_lod_normalizer.md
Name: pipelined_lod_normalizer

Overview:
- Parametrised, pipelined successor to the combinational leading-one detector.
- Finds the leading one of a mantissa, left-shifts it so the MSB is set, and adjusts a biased exponent to match.
- Clamps at exponent zero so results can be subnormal.
- Sits between the FP adder/multiplier datapath and the rounding stage, with a valid/ready elastic interface and 2-cycle latency.

Parameters:
- WIDTH, 8, mantissa width in bits; must be >= 2.
- EXP_WIDTH, 8, width of the unsigned biased exponent.
- POS_WIDTH, $clog2(WIDTH), width of the position and shift fields; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_mant  input  WIDTH  unnormalised mantissa.
- in_exp  input  EXP_WIDTH  biased exponent of in_mant.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_mant  output  WIDTH  normalised (or partially normalised) mantissa.
- out_exp  output  EXP_WIDTH  adjusted exponent.
- out_pos  output  POS_WIDTH  bit index of the leading one in in_mant; 0 when out_zero.
- out_zero  output  1  in_mant was all zeros.
- out_underflow  output  1  shift was limited by the exponent; result is subnormal.

Behaviour:
- Interface: one clock domain. Reset is asynchronous and active-high on rst; clock port clk.
- Reset: s1_valid and s2_valid clear to 0 immediately. All data registers clear to 0, so out_mant, out_exp, out_pos, out_zero, out_underflow = 0.
- After reset, out_valid = 0 and in_ready = 1.
- Pipeline, two register stages:
  - S1 registers in_mant, in_exp, the leading-one position p (highest set bit index) and a zero flag.
  - S2 registers the shifted mantissa, the adjusted exponent and the flags.
- Handshake:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1. This is the only combinational input-to-output path (out_ready -> in_ready).
  - A transfer occurs on in_valid && in_ready, and on out_valid && out_ready.
- Stage movement:
  - When adv1 holds: S1 loads the input beat, and s1_valid <= in_valid.
  - When adv2 holds: S2 loads S1, and s2_valid <= s1_valid.
  - A stalled stage holds every register unchanged.
- Latency and throughput: with out_ready held high, a beat accepted at edge N appears with out_valid at edge N+2. Throughput is 1 beat per cycle. Output order equals input order. No beat is dropped or duplicated.
- Arithmetic:
  - Requested shift: sh_req = WIDTH-1-p.
  - If in_exp >= sh_req: sh = sh_req, out_exp = in_exp - sh, out_underflow = 0.
  - Otherwise: sh = in_exp, out_exp = 0, out_underflow = 1.
  - out_mant = in_mant << sh; bits shifted out are zeros by construction.
  - out_pos = p, always the unclamped position.
- Zero input (in_mant == 0): out_mant = 0, out_exp = 0, out_pos = 0, out_zero = 1, out_underflow = 0.
- Already normalised (in_mant[WIDTH-1] = 1): sh = 0, out_mant = in_mant, out_exp = in_exp, out_underflow = 0, including when in_exp = 0.
- in_exp = 0 with in_mant nonzero and not normalised: sh = 0, out_exp = 0, out_underflow = 1.
- Full pipeline: both stages valid and out_ready = 0 gives in_ready = 0. Data must be held stable until accepted.
- Simultaneous events: out_ready = 1 while full lets S2 drain, S1 move to S2 and a new beat enter, all on the same edge.
- Reset mid-operation: in-flight beats are discarded, with no output after reset deasserts until new input arrives.
- out_* data values are don't-care while out_valid = 0; the bench checks them only on transfer.

Test Plan:
- WIDTH=8, EXP_WIDTH=5, out_ready=1; in_mant=0000_0101, in_exp=10 -> two cycles later: out_mant=1010_0000, out_exp=5, out_pos=2, out_zero=0, out_underflow=0.
- in_mant=0000_0101, in_exp=3 -> out_mant=0010_1000, out_exp=0, out_pos=2, out_underflow=1.
- Boundary beats:
  - in_mant=0, in_exp=17 -> out_mant=0, out_exp=0, out_pos=0, out_zero=1.
  - in_mant=1000_0000, in_exp=0 -> out_mant=1000_0000, out_exp=0, out_pos=7, out_underflow=0.
- Backpressure: send beats A, B, C on consecutive cycles with out_ready=0 -> A and B accepted, in_ready=0 while C is held. Release out_ready -> A, B, C emerge in order with correct values and no duplicates.
- Random stream of 1000 beats with random in_valid and out_ready -> every output matches a reference model in order; in_ready never drops while a stage is empty.
- Assert rst asynchronously (mid-cycle) with 2 beats in flight -> out_valid falls immediately and all outputs read 0. After release, no output until a new beat is sent; then normal 2-cycle latency.
